// File: rtl/eprom_read_ctrl.sv
// eprom_read_ctrl: valid/ready read initiator for a 2732-style asynchronous EPROM
module eprom_read_ctrl #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 8,
   parameter int T_SETUP = 1,
   parameter int T_ACC   = 4,
   parameter int T_REC   = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              busy,
   output logic [ADDR_W-1:0] rom_a,
   output logic              rom_e_n,
   output logic              rom_g_n,
   input  logic [DATA_W-1:0] rom_q
);
   localparam int T_MAX = (T_SETUP > T_ACC) ? ((T_SETUP > T_REC) ? T_SETUP : T_REC)
                                            : ((T_ACC > T_REC) ? T_ACC : T_REC);
   localparam int CW = $clog2(T_MAX + 1);
   localparam logic [CW-1:0] LD_S = CW'((T_SETUP > 0) ? T_SETUP - 1 : 0);
   localparam logic [CW-1:0] LD_A = CW'(T_ACC - 1);
   localparam logic [CW-1:0] LD_R = CW'((T_REC > 0) ? T_REC - 1 : 0);
   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RESP, RECOVER} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic last;
   assign last      = (cnt == '0);
   assign req_ready = (state == IDLE) && !reset;
   assign busy      = (state != IDLE);
   // next state and counter reload on every state entry
   always_comb begin
      state_nx = state;
      cnt_nx   = last ? cnt : cnt - 1'b1;
      case (state)
         IDLE: begin
            if (req_valid) begin
               state_nx = (T_SETUP > 0) ? SETUP : ACCESS;
               cnt_nx   = (T_SETUP > 0) ? LD_S : LD_A;
            end
         end
         SETUP: begin
            if (last) begin
               state_nx = ACCESS;
               cnt_nx   = LD_A;
            end
         end
         ACCESS: begin
            if (last) begin
               state_nx = RESP;
               cnt_nx   = '0;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_nx = (T_REC > 0) ? RECOVER : IDLE;
               cnt_nx   = (T_REC > 0) ? LD_R : '0;
            end
         end
         RECOVER: begin
            if (last) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end
   // state, strobes, address latch and response capture; strobes are low exactly while in ACCESS
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         rom_a     <= '0;
         rom_e_n   <= 1'b1;
         rom_g_n   <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         rom_e_n   <= (state_nx != ACCESS);
         rom_g_n   <= (state_nx != ACCESS);
         rsp_valid <= (state_nx == RESP);
         if (state == IDLE && req_valid) rom_a <= req_addr;
         if (state == ACCESS && last) rsp_data <= rom_q;
      end
   end
endmodule

// File: tb/tb_eprom_read_ctrl.sv
// tb_eprom_read_ctrl: scoreboard bench for eprom_read_ctrl with a 2732 behavioural model
module tb_eprom_read_ctrl;
   localparam int T_SETUP = 1;
   localparam int T_ACC   = 4;
   localparam int T_REC   = 1;
   localparam int LAT     = T_SETUP + T_ACC + 1;
   localparam int PERIOD  = 1 + T_SETUP + T_ACC + 1 + T_REC;
   logic clk, reset;
   logic req_valid, req_ready, rsp_valid, rsp_ready, busy, rom_e_n, rom_g_n;
   logic [11:0] req_addr, rom_a;
   logic [7:0] rsp_data, rom_q;
   logic b_valid, b_ready, b_rsp_valid, b_busy, b_e_n, b_g_n;
   logic [11:0] b_addr, b_a;
   logic [7:0] b_rsp_data, b_q;
   int errors = 0, checks = 0;
   int nc = 0, acc_nc = 0, last_rise = -1, lowcnt = 0, n_rsp = 0;
   logic [11:0] a_low;
   bit prev_rv = 0, chk_period = 0;
   logic [7:0] exp_q[$];

   function automatic logic [7:0] mem_val(input logic [11:0] a);
      return a[7:0] ^ 8'hA5;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   eprom_read_ctrl #(.ADDR_W(12), .DATA_W(8), .T_SETUP(T_SETUP), .T_ACC(T_ACC), .T_REC(T_REC)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy),
      .rom_a(rom_a), .rom_e_n(rom_e_n), .rom_g_n(rom_g_n), .rom_q(rom_q));

   eprom_read_ctrl #(.ADDR_W(12), .DATA_W(8), .T_SETUP(0), .T_ACC(1), .T_REC(0)) dut_fast (
      .clk(clk), .reset(reset), .req_valid(b_valid), .req_ready(b_ready), .req_addr(b_addr),
      .rsp_valid(b_rsp_valid), .rsp_ready(1'b1), .rsp_data(b_rsp_data), .busy(b_busy),
      .rom_a(b_a), .rom_e_n(b_e_n), .rom_g_n(b_g_n), .rom_q(b_q));

   assign rom_q = (!rom_e_n && !rom_g_n) ? mem_val(rom_a) : 8'h00;
   assign b_q   = (!b_e_n && !b_g_n) ? mem_val(b_a) : 8'h00;

   initial clk = 0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // protocol monitor and scoreboard, sampled on the falling edge
   always @(negedge clk) begin
      nc++;
      if (reset) begin
         exp_q.delete();
         lowcnt  = 0;
         prev_rv = 0;
      end else begin
         check("eg_equal", 32'(rom_e_n), 32'(rom_g_n));
         if (!rom_e_n) begin
            if (lowcnt == 0) a_low = rom_a;
            else check("a_stable", 32'(rom_a), 32'(a_low));
            lowcnt++;
         end else if (lowcnt > 0) begin
            check("eg_low_cycles", lowcnt, T_ACC);
            lowcnt = 0;
         end
         if (req_valid && req_ready) begin
            exp_q.push_back(mem_val(req_addr));
            acc_nc = nc;
         end
         if (rsp_valid && !prev_rv) begin
            check("latency", nc - acc_nc, LAT);
            if (chk_period && last_rise >= 0) check("period", nc - last_rise, PERIOD);
            last_rise = nc;
         end
         if (rsp_valid && rsp_ready) begin
            n_rsp++;
            check("sb_nonempty", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("rsp_data", 32'(rsp_data), 32'(exp_q.pop_front()));
         end
         prev_rv = rsp_valid;
      end
   end

   task automatic send(input logic [11:0] a, input bit hold);
      int n = 0;
      req_valid = 1;
      req_addr  = a;
      @(negedge clk);
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("accept_timeout", 32'(req_ready), 1);
      @(posedge clk);
      #1;
      if (!hold) req_valid = 0;
   endtask

   task automatic wait_rsp();
      int n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("rsp_seen", 32'(rsp_valid), 1);
   endtask

   initial begin
      int base;
      reset = 1; req_valid = 0; req_addr = '0; rsp_ready = 1; b_valid = 0; b_addr = '0;
      repeat (3) begin
         @(negedge clk);
         check("rst_req_ready", 32'(req_ready), 0);
      end
      check("rst_e_n", 32'(rom_e_n), 1);
      check("rst_g_n", 32'(rom_g_n), 1);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rom_a", 32'(rom_a), 0);
      check("rst_rsp_data", 32'(rsp_data), 0);
      check("rst_busy", 32'(busy), 0);
      @(posedge clk); #1 reset = 0;
      @(negedge clk);
      check("rel_req_ready", 32'(req_ready), 1);
      // single read
      @(posedge clk); #1;
      send(12'h003, 0);
      wait_rsp();
      check("single_data", 32'(rsp_data), 32'h0A6);
      check("single_rom_a", 32'(rom_a), 32'h003);
      @(posedge clk); #1;
      // back-to-back with req_valid held
      chk_period = 1;
      last_rise  = -1;
      base       = n_rsp;
      for (int i = 0; i < 10; i++) send(12'(i), 1);
      req_valid = 0;
      wait_rsp();
      @(posedge clk); #1;
      chk_period = 0;
      check("b2b_count", n_rsp - base, 10);
      check("b2b_drained", exp_q.size(), 0);
      // backpressure
      rsp_ready = 0;
      send(12'hFFF, 0);
      wait_rsp();
      repeat (10) begin
         @(negedge clk);
         check("bp_rsp_valid", 32'(rsp_valid), 1);
         check("bp_rsp_data", 32'(rsp_data), 32'h05A);
         check("bp_e_n", 32'(rom_e_n), 1);
         check("bp_g_n", 32'(rom_g_n), 1);
         check("bp_req_ready", 32'(req_ready), 0);
      end
      @(posedge clk); #1 rsp_ready = 1;
      @(posedge clk);
      @(negedge clk);
      check("rec_rsp_valid", 32'(rsp_valid), 0);
      check("rec_busy", 32'(busy), 1);
      check("rec_req_ready", 32'(req_ready), 0);
      check("rec_rsp_data_hold", 32'(rsp_data), 32'h05A);
      @(negedge clk);
      check("idle_req_ready", 32'(req_ready), 1);
      check("idle_busy", 32'(busy), 0);
      // reset during the second ACCESS cycle
      @(posedge clk); #1;
      send(12'h010, 0);
      @(posedge clk);
      @(posedge clk); #1 reset = 1;
      @(negedge clk);
      check("mid_access_e_n", 32'(rom_e_n), 0);
      @(negedge clk);
      check("mid_rst_e_n", 32'(rom_e_n), 1);
      check("mid_rst_g_n", 32'(rom_g_n), 1);
      check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_rom_a", 32'(rom_a), 0);
      @(posedge clk); #1 reset = 0;
      repeat (6) begin
         @(negedge clk);
         check("no_rsp_after_rst", 32'(rsp_valid), 0);
      end
      @(posedge clk); #1;
      send(12'h011, 0);
      wait_rsp();
      check("post_rst_data", 32'(rsp_data), 32'h0B4);
      @(posedge clk); #1;
      // minimal timing instance
      b_valid = 1;
      b_addr  = 12'h020;
      @(negedge clk);
      check("fast_ready", 32'(b_ready), 1);
      @(posedge clk); #1 b_valid = 0;
      @(negedge clk);
      check("fast_access_e_n", 32'(b_e_n), 0);
      check("fast_access_rsp_valid", 32'(b_rsp_valid), 0);
      @(negedge clk);
      check("fast_rsp_valid", 32'(b_rsp_valid), 1);
      check("fast_rsp_data", 32'(b_rsp_data), 32'h085);
      check("fast_resp_e_n", 32'(b_e_n), 1);
      @(negedge clk);
      check("fast_next_ready", 32'(b_ready), 1);
      check("fast_rsp_done", 32'(b_rsp_valid), 0);
      check("fast_data_hold", 32'(b_rsp_data), 32'h085);
      repeat (3) @(negedge clk);
      check("sb_final_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
